// File: rtl/udp_rx_chk_pkg.sv
// Shared types and pattern helpers for the UDP RX pattern checker.
// Helpers assume 64-byte beats (512-bit datapath).
package udp_rx_chk_pkg;

    typedef enum logic {
        IDLE,
        IN_PKT
    } rx_state_e;

    localparam int PATTERN_WORD_W = 32;

    function automatic logic [PATTERN_WORD_W-1:0] pattern_word(
        input logic [15:0] seq,
        input logic [15:0] beat
    );
        return {seq, beat};
    endfunction

    function automatic logic [63:0] last_keep_mask(
        input logic [15:0] pkt_size
    );
        logic [5:0] rem;
        logic [6:0] n;
        rem = 6'(pkt_size - 16'd1);
        n   = {1'b0, rem} + 7'd1;
        return (n == 7'd64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [16:0] exp_beats(
        input logic [15:0] pkt_size
    );
        return 17'(({1'b0, pkt_size} + 17'd63) >> 6);
    endfunction

endpackage

// File: rtl/udp_rx_chk_beat_cmp.sv
// Registered masked compare of one RX beat against its replicated
// pattern word; mismatch is valid the cycle after the beat is captured.
module udp_rx_chk_beat_cmp
    import udp_rx_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic [KEEP_WIDTH-1:0]     i_keep,
    input  logic [PATTERN_WORD_W-1:0] i_exp_word,
    output logic                      o_mismatch
);

    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [KEEP_WIDTH-1:0]     r_keep;
    logic [PATTERN_WORD_W-1:0] r_exp;
    logic                      w_diff;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_exp   <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_keep <= i_keep;
                r_exp  <= i_exp_word;
            end
        end
    end

    always_comb begin
        w_diff = 1'b0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (r_keep[k] && (r_data[k*8 +: 8] != r_exp[(k%4)*8 +: 8]))
                w_diff = 1'b1;
        end
    end

    assign o_mismatch = r_valid & w_diff;

endmodule

// File: rtl/udp_rx_pattern_checker.sv
// RX pattern checker / perf monitor for the UDP loopback path.
// Optional first-error capture: UDP_RX_CHK_FIRST_ERR_CAPTURE_EN.
module udp_rx_pattern_checker
    import udp_rx_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  udp_clk,
    input  logic                  udp_reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic [15:0]           cfg_pkt_size,
    input  logic                  cfg_recv_enable,
    output logic [CNT_WIDTH-1:0]  recv_pkt_num_count,
    output logic [CNT_WIDTH-1:0]  err_pkt_num_count,
    output logic [CNT_WIDTH-1:0]  total_beat_count,
    output logic [CNT_WIDTH-1:0]  perf_cycle_count,
    output logic [CNT_WIDTH-1:0]  perf_beat_count,
    output logic                  perf_cycle_count_full,
    output logic                  is_recv_first_pkt,
    output logic                  first_err_valid,
    output logic [15:0]           first_err_seq,
    output logic [15:0]           first_err_beat
);

    rx_state_e r_state, w_state_nxt;

    logic [15:0] r_pkt_seq, r_beat_idx, r_exp_seq;
    logic        r_counted, r_synced;
    logic        r_p1_valid, r_p1_counted, r_p1_sop;
    logic        r_p1_last, r_p1_ferr;
    logic        r_pkt_err, r_p2_valid, r_p2_last, r_p2_err;
    logic        r_perf_run, r_perf_full;

    logic [CNT_WIDTH-1:0] r_recv, r_err, r_total;
    logic [CNT_WIDTH-1:0] r_perf_cyc, r_perf_beat, w_cyc_nxt;

    logic                      w_sop, w_counted, w_seq_err, w_ferr;
    logic                      w_mismatch, w_acc, w_perf_tick;
    logic [15:0]               w_rx_seq, w_pkt_seq, w_beat;
    logic [KEEP_WIDTH-1:0]     w_last_keep;
    logic [PATTERN_WORD_W-1:0] w_exp_word;

    assign s_axis_tready = 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (s_axis_tvalid)
            w_state_nxt = s_axis_tlast ? IDLE : IN_PKT;
    end

    assign w_sop       = s_axis_tvalid && (r_state == IDLE);
    assign w_rx_seq    = s_axis_tdata[31:16];
    assign w_pkt_seq   = w_sop ? w_rx_seq : r_pkt_seq;
    assign w_beat      = w_sop ? 16'd0 : r_beat_idx;
    assign w_counted   = w_sop ? cfg_recv_enable : r_counted;
    assign w_exp_word  = pattern_word(w_pkt_seq, w_beat);
    assign w_last_keep = KEEP_WIDTH'(last_keep_mask(cfg_pkt_size));
    assign w_seq_err   = w_sop && r_synced && (w_rx_seq != r_exp_seq);

    // Framing faults are known at accept time; data compare lands at T+1.
    assign w_ferr = s_axis_tuser[0]
                  | (cfg_pkt_size == 16'd0)
                  | w_seq_err
                  | (!s_axis_tlast && (s_axis_tkeep != '1))
                  | (s_axis_tlast && (s_axis_tkeep != w_last_keep))
                  | (s_axis_tlast &&
                     (({1'b0, w_beat} + 17'd1) != exp_beats(cfg_pkt_size)));

    always_ff @(posedge udp_clk) begin
        if (udp_reset) begin
            r_state      <= IDLE;
            r_pkt_seq    <= '0;
            r_beat_idx   <= '0;
            r_counted    <= 1'b0;
            r_synced     <= 1'b0;
            r_exp_seq    <= '0;
            r_p1_valid   <= 1'b0;
            r_p1_counted <= 1'b0;
            r_p1_sop     <= 1'b0;
            r_p1_last    <= 1'b0;
            r_p1_ferr    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_p1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_pkt_seq    <= w_pkt_seq;
                r_beat_idx   <= (w_beat == 16'hFFFF) ? w_beat
                                                     : w_beat + 16'd1;
                r_counted    <= w_counted;
                r_p1_counted <= w_counted;
                r_p1_sop     <= w_sop;
                r_p1_last    <= s_axis_tlast;
                r_p1_ferr    <= w_ferr;
                if (w_sop && cfg_recv_enable) begin
                    r_synced  <= 1'b1;
                    r_exp_seq <= w_rx_seq + 16'd1;
                end
            end
        end
    end

    udp_rx_chk_beat_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_cmp (
        .i_clk      (udp_clk),
        .i_reset    (udp_reset),
        .i_valid    (s_axis_tvalid),
        .i_data     (s_axis_tdata),
        .i_keep     (s_axis_tkeep),
        .i_exp_word (w_exp_word),
        .o_mismatch (w_mismatch)
    );

    assign w_acc = (r_p1_sop ? 1'b0 : r_pkt_err) | r_p1_ferr | w_mismatch;

    always_ff @(posedge udp_clk) begin
        if (udp_reset) begin
            r_pkt_err  <= 1'b0;
            r_p2_valid <= 1'b0;
            r_p2_last  <= 1'b0;
            r_p2_err   <= 1'b0;
        end else begin
            r_p2_valid <= r_p1_valid & r_p1_counted;
            if (r_p1_valid) begin
                r_pkt_err <= w_acc;
                r_p2_last <= r_p1_last;
                r_p2_err  <= w_acc;
            end
        end
    end

    assign w_perf_tick = (r_perf_run | r_p2_valid) & ~r_perf_full;
    assign w_cyc_nxt   = r_perf_cyc + 1'b1;

    always_ff @(posedge udp_clk) begin
        if (udp_reset) begin
            r_recv      <= '0;
            r_err       <= '0;
            r_total     <= '0;
            r_perf_run  <= 1'b0;
            r_perf_full <= 1'b0;
            r_perf_cyc  <= '0;
            r_perf_beat <= '0;
        end else begin
            if (r_p2_valid) begin
                r_total    <= r_total + 1'b1;
                r_perf_run <= 1'b1;
                if (r_p2_last) begin
                    r_recv <= r_recv + 1'b1;
                    r_err  <= r_err + CNT_WIDTH'(r_p2_err);
                end
            end
            if (w_perf_tick) begin
                r_perf_cyc  <= w_cyc_nxt;
                r_perf_full <= (w_cyc_nxt == '1);
                r_perf_beat <= r_perf_beat + CNT_WIDTH'(r_p2_valid);
            end
        end
    end

    assign recv_pkt_num_count    = r_recv;
    assign err_pkt_num_count     = r_err;
    assign total_beat_count      = r_total;
    assign perf_cycle_count      = r_perf_cyc;
    assign perf_beat_count       = r_perf_beat;
    assign perf_cycle_count_full = r_perf_full;
    assign is_recv_first_pkt     = r_synced;

`ifdef UDP_RX_CHK_FIRST_ERR_CAPTURE_EN
    logic [15:0] r_p1_seq, r_p1_beat, r_fe_seq, r_fe_beat;
    logic        r_fe_valid;

    always_ff @(posedge udp_clk) begin
        if (udp_reset) begin
            r_p1_seq   <= '0;
            r_p1_beat  <= '0;
            r_fe_valid <= 1'b0;
            r_fe_seq   <= '0;
            r_fe_beat  <= '0;
        end else begin
            if (s_axis_tvalid) begin
                r_p1_seq  <= w_pkt_seq;
                r_p1_beat <= w_beat;
            end
            if (r_p1_valid && r_p1_counted && w_mismatch && !r_fe_valid) begin
                r_fe_valid <= 1'b1;
                r_fe_seq   <= r_p1_seq;
                r_fe_beat  <= r_p1_beat;
            end
        end
    end

    assign first_err_valid = r_fe_valid;
    assign first_err_seq   = r_fe_seq;
    assign first_err_beat  = r_fe_beat;
`else
    assign first_err_valid = 1'b0;
    assign first_err_seq   = 16'd0;
    assign first_err_beat  = 16'd0;
`endif

endmodule
